fetch_pc_gen: RTL and testbench

- Fetch-stage next-PC generator that sits directly downstream of the gshare branch predictor.
- Holds the fetch PC that drives i_IMEM_address and the predictor index.
- Looks up a direct-mapped branch target buffer (BTB) for that PC and combines a BTB hit with the predictor's o_taken to choose the next PC.
- Takes redirects and BTB updates from the ALU stage when a branch resolves.

---
 rtl/fetch_pc_gen.sv | 134 +++++++++++++
 tb/tb_fetch_pc_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch-stage next-PC generator with a direct-mapped BTB.
// Holds the fetch PC, looks up the BTB for that PC, and combines a BTB hit
// with the gshare predictor's taken bit to pick the next PC. ALU-stage
// redirects and BTB updates are applied when branches resolve.
//
// Optional feature macro: BTB_BYPASS_EN
//   defined   -> a BTB write whose PC equals the current fetch PC is
//                forwarded to the same-cycle lookup.
//   undefined -> the same-cycle lookup sees the previously stored entry.
module fetch_pc_gen #(
    parameter int                       ADDRESS_WIDTH  = 22,
    parameter int                       BTB_INDEX_BITS = 6,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC       = '0
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic                     i_Stall,
    input  logic                     i_pred_taken,
    input  logic                     i_ALU_redirect,
    input  logic [ADDRESS_WIDTH-1:0] i_ALU_redirect_pc,
    input  logic                     i_ALU_update,
    input  logic [ADDRESS_WIDTH-1:0] i_ALU_pc,
    input  logic [ADDRESS_WIDTH-1:0] i_ALU_target,
    output logic [ADDRESS_WIDTH-1:0] o_IMEM_address,
    output logic                     o_btb_hit,
    output logic                     o_prediction,
    output logic [ADDRESS_WIDTH-1:0] o_pred_target,
    output logic                     o_flush
);

    localparam int TAG_W = ADDRESS_WIDTH - BTB_INDEX_BITS;
    localparam int DEPTH = 1 << BTB_INDEX_BITS;

    // Architectural state
    logic [ADDRESS_WIDTH-1:0] pc_reg;
    logic [ADDRESS_WIDTH-1:0] pc_next;
    logic                     flush_reg;

    // BTB storage: valid bits are resettable, tag/target arrays are not
    logic [DEPTH-1:0]         valid_reg;
    logic [DEPTH-1:0]         valid_set;
    logic [TAG_W-1:0]         tag_mem    [DEPTH];
    logic [ADDRESS_WIDTH-1:0] target_mem [DEPTH];

    // Lookup / write decode
    logic [BTB_INDEX_BITS-1:0] lookup_idx;
    logic [TAG_W-1:0]          lookup_tag;
    logic [BTB_INDEX_BITS-1:0] wr_idx;
    logic [TAG_W-1:0]          wr_tag;
    logic                      wr_en;

    logic                      stored_hit;
    logic [ADDRESS_WIDTH-1:0]  stored_target;
    logic                      hit;
    logic [ADDRESS_WIDTH-1:0]  target;
    logic                      prediction;

    assign lookup_idx = pc_reg[BTB_INDEX_BITS-1:0];
    assign lookup_tag = pc_reg[ADDRESS_WIDTH-1:BTB_INDEX_BITS];
    assign wr_idx     = i_ALU_pc[BTB_INDEX_BITS-1:0];
    assign wr_tag     = i_ALU_pc[ADDRESS_WIDTH-1:BTB_INDEX_BITS];
    assign wr_en      = i_ALU_update & ~i_Reset;

    // Per-entry write decode used to set valid bits
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid_set
            assign valid_set[gi] = wr_en && (wr_idx == BTB_INDEX_BITS'(gi));
        end
    endgenerate

    // Combinational BTB read of the stored entry
    assign stored_hit    = valid_reg[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);
    assign stored_target = target_mem[lookup_idx];

`ifdef BTB_BYPASS_EN
    // Forward an in-flight write for exactly this PC to the lookup
    logic bypass;
    assign bypass = wr_en && (i_ALU_pc == pc_reg);
    assign hit    = bypass | stored_hit;
    assign target = bypass ? i_ALU_target : stored_target;
`else
    assign hit    = stored_hit;
    assign target = stored_target;
`endif

    assign prediction = hit & i_pred_taken;

    // Next-PC selection: redirect beats stall beats predicted-taken beats PC+1
    always_comb begin
        pc_next = pc_reg + ADDRESS_WIDTH'(1);
        if (i_ALU_redirect) begin
            pc_next = i_ALU_redirect_pc;
        end else if (i_Stall) begin
            pc_next = pc_reg;
        end else if (prediction) begin
            pc_next = target;
        end
    end

    // PC and flush registers; reset overrides everything
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            pc_reg    <= RESET_PC;
            flush_reg <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            flush_reg <= i_ALU_redirect;
        end
    end

    // Valid bits: cleared on reset, set by ALU updates (never gated by stall)
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_reg | valid_set;
        end
    end

    // Tag/target storage written on ALU update; contents survive reset
    always_ff @(posedge i_Clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]    <= wr_tag;
            target_mem[wr_idx] <= i_ALU_target;
        end
    end

    assign o_IMEM_address = pc_reg;
    assign o_btb_hit      = hit;
    assign o_prediction   = prediction;
    assign o_pred_target  = hit ? target : '0;
    assign o_flush        = flush_reg;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: scoreboard bench for fetch_pc_gen. The driver pushes the
// reference model's expected outputs for every cycle; a monitor pops and
// compares them against the DUT a little after each falling edge.
module tb_fetch_pc_gen;

    localparam int AW     = 22;
    localparam int IB     = 6;
    localparam int NENT   = 1 << IB;
    localparam int PCMOD  = 1 << AW;
    localparam int RST_PC = 'h10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stall = 1'b0;
    logic          taken = 1'b0;
    logic          redir = 1'b0;
    logic [AW-1:0] redir_pc = '0;
    logic          upd = 1'b0;
    logic [AW-1:0] upd_pc = '0;
    logic [AW-1:0] upd_tgt = '0;
    logic [AW-1:0] imem_addr;
    logic          btb_hit;
    logic          prediction;
    logic [AW-1:0] pred_target;
    logic          flush;

    fetch_pc_gen #(
        .ADDRESS_WIDTH (AW),
        .BTB_INDEX_BITS(IB),
        .RESET_PC      (22'h10)
    ) dut (
        .i_Clk            (clk),
        .i_Reset          (rst),
        .i_Stall          (stall),
        .i_pred_taken     (taken),
        .i_ALU_redirect   (redir),
        .i_ALU_redirect_pc(redir_pc),
        .i_ALU_update     (upd),
        .i_ALU_pc         (upd_pc),
        .i_ALU_target     (upd_tgt),
        .o_IMEM_address   (imem_addr),
        .o_btb_hit        (btb_hit),
        .o_prediction     (prediction),
        .o_pred_target    (pred_target),
        .o_flush          (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   pc;
        bit   hit;
        bit   pred;
        int   tgt;
        bit   flush;
        int   id;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn_id = 0;

    // Reference model: BTB remembers the full branch PC per slot
    bit m_init = 0;
    int m_pc = 0;
    bit m_flush = 0;
    bit m_valid [NENT];
    int m_bpc   [NENT];
    int m_btgt  [NENT];

    task automatic cyc(input bit r, input bit st, input bit tk, input bit rd, input int rpc,
                       input bit up, input int upc, input int utg);
        exp_t e;
        int   slot;
        bit   h;
        int   t;
        @(negedge clk);
        rst = r; stall = st; taken = tk; redir = rd; redir_pc = rpc[AW-1:0];
        upd = up; upd_pc = upc[AW-1:0]; upd_tgt = utg[AW-1:0];
        slot = m_pc % NENT;
        h = m_valid[slot] && (m_bpc[slot] == m_pc);
        t = m_btgt[slot];
`ifdef BTB_BYPASS_EN
        if (up && !r && upc == m_pc) begin
            h = 1'b1;
            t = utg;
        end
`endif
        if (m_init && !r) begin
            e.pc = m_pc; e.hit = h; e.pred = h && tk; e.tgt = h ? t : 0;
            e.flush = m_flush; e.id = txn_id;
            q.push_back(e);
        end
        txn_id++;
        // Advance the model across the coming rising edge
        if (r) begin
            m_init = 1;
            m_pc = RST_PC;
            m_flush = 0;
            for (int i = 0; i < NENT; i++) m_valid[i] = 0;
        end else begin
            m_flush = rd;
            if (rd)                m_pc = rpc;
            else if (st)           m_pc = m_pc;
            else if (h && tk)      m_pc = t;
            else                   m_pc = (m_pc + 1) % PCMOD;
            if (up) begin
                m_valid[upc % NENT] = 1;
                m_bpc[upc % NENT]   = upc;
                m_btgt[upc % NENT]  = utg;
            end
        end
    endtask

    task automatic idle(input bit tk);
        cyc(0, 0, tk, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare DUT outputs against the oldest expectation each cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (imem_addr !== e.pc[AW-1:0] || btb_hit !== e.hit || prediction !== e.pred ||
                    pred_target !== e.tgt[AW-1:0] || flush !== e.flush) begin
                    errors++;
                    $display("FAIL cycle%0d got pc=%h hit=%b pred=%b tgt=%h flush=%b required pc=%h hit=%b pred=%b tgt=%h flush=%b",
                             e.id, imem_addr, btb_hit, prediction, pred_target, flush,
                             e.pc[AW-1:0], e.hit, e.pred, e.tgt[AW-1:0], e.flush);
                end else begin
                    $display("txn %0d pc=%h hit=%b pred=%b tgt=%h flush=%b",
                             e.id, imem_addr, btb_hit, prediction, pred_target, flush);
                end
            end
        end
    end

    initial begin
        int rpc;
        int upc;
        // Reset and free run from 0x10
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) idle(0);
        // Install 0x15 -> 0x40, then run with taken held high through the hit
        cyc(0, 0, 0, 0, 0, 1, 'h15, 'h40);
        for (int i = 0; i < 5; i++) idle(1);
        // Same branch, predictor says not taken -> fall through to 0x16
        cyc(0, 0, 0, 1, 'h15, 0, 0, 0);
        idle(0);
        idle(0);
        // Alias at 0x55 misses, then evict 0x15 with 0x55 and look up 0x15
        cyc(0, 0, 1, 1, 'h55, 0, 0, 0);
        idle(1);
        cyc(0, 0, 0, 0, 0, 1, 'h55, 'h80);
        cyc(0, 0, 1, 1, 'h15, 0, 0, 0);
        idle(1);
        idle(1);
        // Redirect while stalled, then keep stalling
        cyc(0, 1, 0, 1, 'h200, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        idle(0);
        // Wrap at the top of the address space
        cyc(0, 0, 1, 1, 'h3FFFFF, 0, 0, 0);
        idle(1);
        idle(1);
        // Same-cycle update and lookup of the current PC
        cyc(0, 0, 0, 1, 'h30, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 1, 'h30, 'h99);
        idle(1);
        // Back-to-back redirects keep flush high
        cyc(0, 0, 0, 1, 'h100, 0, 0, 0);
        cyc(0, 0, 0, 1, 'h180, 0, 0, 0);
        idle(0);
        idle(0);
        // Reset together with redirect and update; reset must win
        cyc(1, 0, 0, 1, 'h300, 1, 'h10, 'h77);
        idle(1);
        idle(1);
        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5, 6: rpc = $urandom_range(0, 'h3FF);
                7:                   rpc = 'h3FFFF0 + $urandom_range(0, 15);
                default:             rpc = $urandom_range(0, PCMOD - 1);
            endcase
            if ($urandom_range(0, 1) == 0)
                upc = (m_pc + $urandom_range(0, 8)) % PCMOD;
            else
                upc = ($urandom_range(0, 3) * NENT) + $urandom_range(0, NENT - 1);
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, rpc,
                $urandom_range(0, 3) == 0, upc, $urandom_range(0, PCMOD - 1));
        end
        idle(0);
        @(negedge clk);
        #5;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
